// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle between the fetch controller
// (master) and the instruction memory (slave).
interface fetch_ctrl_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding instruction-memory transaction,
// presents fetched words to decode and follows branch/jump redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    fetch_ctrl_if.master imem,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        flush_o,
    output logic        misalign_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        DROP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] instr_next;
    logic [31:0] instr_pc_next;
    logic        redirect;
    logic        misaligned;

    // Misaligned targets are reported but otherwise behave as if no redirect came.
    assign redirect   = redirect_valid_i && (redirect_pc_i[1:0] == 2'b00);
    assign misaligned = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_o    <= '0;
            instr_pc_o <= '0;
            flush_o    <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr_o    <= instr_next;
            instr_pc_o <= instr_pc_next;
            flush_o    <= redirect;
            misalign_o <= misaligned;
        end
    end

    always_comb begin
        state_next        = state;
        pc_next           = redirect ? redirect_pc_i : pc;
        instr_next        = instr_o;
        instr_pc_next     = instr_pc_o;
        imem.imem_req_o   = 1'b0;
        imem.imem_addr_o  = '0;
        instr_valid_o     = 1'b0;

        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                imem.imem_req_o  = 1'b1;
                imem.imem_addr_o = pc;
                if (imem.imem_gnt_i) begin
                    state_next = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid_i) begin
                    if (redirect) begin
                        state_next = REQ;
                    end else begin
                        state_next    = OUT;
                        instr_next    = imem.imem_rdata_i;
                        instr_pc_next = pc;
                    end
                end else if (redirect) begin
                    state_next = DROP;
                end
            end
            OUT: begin
                instr_valid_o = 1'b1;
                if (redirect) begin
                    state_next = REQ;
                end else if (!stall_i) begin
                    pc_next    = pc + 32'd4;
                    state_next = REQ;
                end
            end
            // A redirect landing together with the stale response still retires it,
            // otherwise DROP would wait for a response that never comes.
            DROP: begin
                if (imem.imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written reset
// sequence, and a randomized run against a transaction-level fetch model.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    localparam logic [31:0] D0   = 32'hCAFE_0000;
    localparam logic [31:0] D1   = 32'hCAFE_0004;
    localparam logic [31:0] D2   = 32'h00A0_0093;
    localparam logic [31:0] D3   = 32'h1111_1111;
    localparam logic [31:0] D4   = 32'h2222_2222;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
    localparam logic [31:0] D5   = 32'h3333_3333;
    localparam logic [31:0] D6   = 32'h4444_4444;
    localparam logic [31:0] D7   = 32'h5555_5555;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        flush_o;
    logic        misalign_o;

    int tests = 0;
    int failures = 0;

    fetch_ctrl_if imem ();

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem             (imem.master),
        .instr_valid_o    (instr_valid_o),
        .instr_o          (instr_o),
        .instr_pc_o       (instr_pc_o),
        .flush_o          (flush_o),
        .misalign_o       (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        flush;
        logic        mis;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(input logic stall, input logic rv, input logic [31:0] rpc,
                                input logic gnt, input logic rvalid, input logic [31:0] rdata,
                                input logic req, input logic [31:0] addr, input logic valid,
                                input logic [31:0] instr, input logic [31:0] ipc,
                                input logic flush, input logic mis);
        vec_t v;
        v.stall = stall; v.rv = rv; v.rpc = rpc; v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata;
        v.req = req; v.addr = addr; v.valid = valid; v.instr = instr; v.ipc = ipc;
        v.flush = flush; v.mis = mis;
        return v;
    endfunction

    // Memory contents seen by the random run: a fixed scramble of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic applyStimulus(input logic stall, input logic rv, input logic [31:0] rpc,
                                 input logic gnt, input logic rvalid, input logic [31:0] rdata);
        stall_i            = stall;
        redirect_valid_i   = rv;
        redirect_pc_i      = rpc;
        imem.imem_gnt_i    = gnt;
        imem.imem_rvalid_i = rvalid;
        imem.imem_rdata_i  = rdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkFlag({tag, ".req"}, imem.imem_req_o, L);
        checkOutput({tag, ".addr"}, imem.imem_addr_o, 32'h0);
        checkFlag({tag, ".valid"}, instr_valid_o, L);
        checkOutput({tag, ".instr"}, instr_o, 32'h0);
        checkOutput({tag, ".ipc"}, instr_pc_o, 32'h0);
        checkFlag({tag, ".flush"}, flush_o, L);
        checkFlag({tag, ".mis"}, misalign_o, L);
    endtask

    logic [31:0] exp_pc;
    logic [31:0] pend_addr;
    logic        pending;
    int          countdown;
    int          consumes;
    logic        prev_valid, prev_stall, prev_al, prev_mis;
    logic [31:0] prev_instr, prev_ipc;
    logic        g, rv, st, rdv, al;
    logic [31:0] rd, rpc;

    initial begin
        applyStimulus(L, L, 32'h0, L, L, 32'h0);

        // Directed flow: sequential fetch, stall hold, misaligned and aligned redirects, wrap.
        vecs[0]  = mk(L,L,32'h0,H,L,32'h0,        L,32'h0,L,32'h0,32'h0,L,L);
        vecs[1]  = mk(L,L,32'h0,H,L,32'h0,        H,32'h0,L,32'h0,32'h0,L,L);
        vecs[2]  = mk(L,L,32'h0,H,H,D0,           L,32'h0,L,32'h0,32'h0,L,L);
        vecs[3]  = mk(L,L,32'h0,H,L,32'h0,        L,32'h0,H,D0,32'h0,L,L);
        vecs[4]  = mk(L,L,32'h0,H,L,32'h0,        H,32'h4,L,D0,32'h0,L,L);
        vecs[5]  = mk(L,L,32'h0,H,H,D1,           L,32'h0,L,D0,32'h0,L,L);
        vecs[6]  = mk(L,L,32'h0,H,L,32'h0,        L,32'h0,H,D1,32'h4,L,L);
        vecs[7]  = mk(L,L,32'h0,H,L,32'h0,        H,32'h8,L,D1,32'h4,L,L);
        vecs[8]  = mk(L,L,32'h0,H,H,D2,           L,32'h0,L,D1,32'h4,L,L);
        for (int i = 9; i <= 13; i++)
            vecs[i] = mk(H,L,32'h0,H,L,32'h0,     L,32'h0,H,D2,32'h8,L,L);
        vecs[14] = mk(L,L,32'h0,H,L,32'h0,        L,32'h0,H,D2,32'h8,L,L);
        vecs[15] = mk(L,L,32'h0,H,L,32'h0,        H,32'hC,L,D2,32'h8,L,L);
        vecs[16] = mk(L,L,32'h0,H,H,D3,           L,32'h0,L,D2,32'h8,L,L);
        vecs[17] = mk(L,H,32'h102,H,L,32'h0,      L,32'h0,H,D3,32'hC,L,L);
        vecs[18] = mk(L,L,32'h0,H,L,32'h0,        H,32'h10,L,D3,32'hC,L,H);
        vecs[19] = mk(L,L,32'h0,H,H,D4,           L,32'h0,L,D3,32'hC,L,L);
        vecs[20] = mk(L,L,32'h0,H,L,32'h0,        L,32'h0,H,D4,32'h10,L,L);
        vecs[21] = mk(L,L,32'h0,H,L,32'h0,        H,32'h14,L,D4,32'h10,L,L);
        vecs[22] = mk(L,H,32'h100,H,L,32'h0,      L,32'h0,L,D4,32'h10,L,L);
        vecs[23] = mk(L,L,32'h0,H,H,DEAD,         L,32'h0,L,D4,32'h10,H,L);
        vecs[24] = mk(L,L,32'h0,H,L,32'h0,        H,32'h100,L,D4,32'h10,L,L);
        vecs[25] = mk(L,L,32'h0,H,H,D5,           L,32'h0,L,D4,32'h10,L,L);
        vecs[26] = mk(L,H,32'hFFFF_FFFC,H,L,32'h0,L,32'h0,H,D5,32'h100,L,L);
        vecs[27] = mk(L,L,32'h0,H,L,32'h0,        H,32'hFFFF_FFFC,L,D5,32'h100,H,L);
        vecs[28] = mk(L,L,32'h0,H,H,D6,           L,32'h0,L,D5,32'h100,L,L);
        vecs[29] = mk(L,L,32'h0,H,L,32'h0,        L,32'h0,H,D6,32'hFFFF_FFFC,L,L);
        vecs[30] = mk(L,L,32'h0,H,L,32'h0,        H,32'h0,L,D6,32'hFFFF_FFFC,L,L);

        #1 rst_n = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
            #1;
            checkFlag($sformatf("v%0d.req", i), imem.imem_req_o, vecs[i].req);
            if (vecs[i].req)
                checkOutput($sformatf("v%0d.addr", i), imem.imem_addr_o, vecs[i].addr);
            checkFlag($sformatf("v%0d.valid", i), instr_valid_o, vecs[i].valid);
            checkOutput($sformatf("v%0d.instr", i), instr_o, vecs[i].instr);
            checkOutput($sformatf("v%0d.ipc", i), instr_pc_o, vecs[i].ipc);
            checkFlag($sformatf("v%0d.flush", i), flush_o, vecs[i].flush);
            checkFlag($sformatf("v%0d.mis", i), misalign_o, vecs[i].mis);
        end

        // Reset while a response is outstanding; the late response lands in IDLE.
        @(negedge clk);
        applyStimulus(L, L, 32'h0, L, L, 32'h0);
        #1 rst_n = 1'b0;
        #1 checkAllZero("rstwait");
        @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(L, L, 32'h0, L, H, 32'hBAD0_BAD0);
        @(negedge clk);
        #1 checkAllZero("idle");
        @(negedge clk);
        applyStimulus(L, L, 32'h0, H, L, 32'h0);
        #1;
        checkFlag("first.req", imem.imem_req_o, H);
        checkOutput("first.addr", imem.imem_addr_o, RESET_PC);
        checkOutput("first.instr", instr_o, 32'h0);
        @(negedge clk);
        applyStimulus(L, L, 32'h0, L, H, D7);
        #1 checkFlag("first.wait", instr_valid_o, L);
        @(negedge clk);
        applyStimulus(L, L, 32'h0, L, L, 32'h0);
        #1;
        checkFlag("first.valid", instr_valid_o, H);
        checkOutput("first.data", instr_o, D7);
        checkOutput("first.ipc", instr_pc_o, RESET_PC);

        // Randomized run against a transaction-level model of the fetch stream.
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(L, L, 32'h0, L, L, 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_pc = RESET_PC;
        pending = 1'b0;
        pend_addr = '0;
        countdown = 0;
        consumes = 0;
        prev_valid = 1'b0; prev_stall = 1'b0; prev_al = 1'b0; prev_mis = 1'b0;
        prev_instr = '0; prev_ipc = '0;

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            checkFlag("rnd.flush", flush_o, prev_al);
            checkFlag("rnd.mis", misalign_o, prev_mis);
            if (prev_valid) begin
                if (prev_stall && !prev_al) begin
                    checkFlag("rnd.hold_valid", instr_valid_o, H);
                    checkOutput("rnd.hold_instr", instr_o, prev_instr);
                    checkOutput("rnd.hold_ipc", instr_pc_o, prev_ipc);
                end else begin
                    checkFlag("rnd.valid_fall", instr_valid_o, L);
                end
            end
            if (instr_valid_o) begin
                checkOutput("rnd.ipc", instr_pc_o, exp_pc);
                checkOutput("rnd.instr", instr_o, memWord(instr_pc_o));
            end
            if (imem.imem_req_o) begin
                checkOutput("rnd.addr", imem.imem_addr_o, exp_pc);
                checkFlag("rnd.outstanding", pending, L);
                checkFlag("rnd.req_vs_valid", instr_valid_o, L);
            end

            g  = imem.imem_req_o && ($urandom_range(2) != 0);
            rv = 1'b0;
            rd = $urandom;
            if (pending) begin
                if (countdown == 0) begin
                    rv = 1'b1;
                    rd = memWord(pend_addr);
                    pending = 1'b0;
                end else begin
                    countdown--;
                end
            end
            st  = ($urandom_range(2) == 0);
            rdv = ($urandom_range(9) == 0);
            rpc = $urandom;
            if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
            applyStimulus(st, rdv, rpc, g, rv, rd);

            al = rdv && (rpc[1:0] == 2'b00);
            if (al) begin
                exp_pc = rpc;
            end else if (instr_valid_o && !st) begin
                exp_pc = exp_pc + 32'd4;
                consumes++;
            end
            if (g) begin
                pending   = 1'b1;
                pend_addr = imem.imem_addr_o;
                countdown = $urandom_range(2);
            end
            prev_valid = instr_valid_o;
            prev_stall = st;
            prev_al    = al;
            prev_mis   = rdv && !al;
            prev_instr = instr_o;
            prev_ipc   = instr_pc_o;
        end
        checkFlag("rnd.progress", consumes >= 100, H);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port stall_i, input, 1 bit: the core cannot accept the presented instruction this cycle.
REQ-005 The block SHALL have port redirect_valid_i, input, 1 bit: one-cycle pulse for a taken branch, jal or jalr.
REQ-006 The block SHALL have port redirect_pc_i, input, 32 bits: redirect target address.
REQ-007 The block SHALL have ports imem_req_o (output, 1 bit), imem_addr_o (output, 32 bits) and imem_gnt_i (input, 1 bit): instruction-memory request handshake.
REQ-008 The block SHALL have ports imem_rvalid_i (input, 1 bit) and imem_rdata_i (input, 32 bits): instruction-memory response.
REQ-009 The block SHALL have ports instr_valid_o (output, 1 bit), instr_o (output, 32 bits) and instr_pc_o (output, 32 bits): instruction presented to decode.
REQ-010 The block SHALL have ports flush_o (output, 1 bit) and misalign_o (output, 1 bit): one-cycle status pulses.

Function
REQ-011 The block SHALL implement the states IDLE, REQ, WAIT, OUT and DROP.
REQ-012 IDLE: all outputs SHALL be 0; the next state SHALL be REQ; imem_rvalid_i SHALL be ignored.
REQ-013 REQ: imem_req_o SHALL be 1 and imem_addr_o SHALL equal pc, held stable until grant; on imem_gnt_i the block SHALL go to WAIT.
REQ-014 WAIT: on imem_rvalid_i the block SHALL register imem_rdata_i into instr_o, register the granted address into instr_pc_o, and go to OUT.
REQ-015 OUT: instr_valid_o SHALL be 1.
REQ-016 OUT with stall_i=0: the instruction is consumed; pc SHALL become pc+4 modulo 2^32 and the next state SHALL be REQ.
REQ-017 OUT with stall_i=1: instr_valid_o, instr_o and instr_pc_o SHALL hold unchanged and no request SHALL be issued.
REQ-018 Minimum fetch period SHALL be 3 cycles (REQ granted, WAIT with rvalid, OUT consumed).
REQ-019 stall_i SHALL have no effect outside OUT.
REQ-020 An aligned redirect (redirect_pc_i[1:0]==0) SHALL load pc from redirect_pc_i and SHALL have priority over every other event in the same cycle.
REQ-021 An aligned redirect SHALL drive flush_o high for exactly one cycle, starting the cycle after the redirect.
REQ-022 Redirect in REQ without grant: the block SHALL stay in REQ, with imem_addr_o showing the new pc from the next cycle.
REQ-023 Redirect in REQ with grant in the same cycle: the block SHALL go to DROP.
REQ-024 Redirect in WAIT without rvalid: the block SHALL go to DROP.
REQ-025 Redirect in WAIT with rvalid in the same cycle: the response SHALL be discarded and the block SHALL go to REQ.
REQ-026 Redirect in OUT: instr_valid_o SHALL fall the next cycle and the block SHALL go to REQ, regardless of stall_i.
REQ-027 Redirect in DROP: pc SHALL be updated and the block SHALL remain in DROP.
REQ-028 DROP: imem_req_o=0 and instr_valid_o=0; on imem_rvalid_i the data SHALL be discarded and the block SHALL go to REQ.
REQ-029 A misaligned redirect (redirect_pc_i[1:0]!=0) SHALL pulse misalign_o for one cycle, leave pc and state unchanged, and not pulse flush_o.
REQ-030 At most one memory transaction SHALL be outstanding at any time.

Reset
REQ-031 While rst_n=0, the block SHALL asynchronously force state=IDLE, pc=RESET_PC, and all outputs to 0, including instr_o and instr_pc_o.
REQ-032 After reset releases, the first request SHALL be issued in the second rising edge's cycle (IDLE then REQ).
REQ-033 A response arriving after reset from a transaction granted before reset SHALL be ignored in IDLE.

Verification
REQ-034 The bench SHALL apply: imem_gnt_i=1, rvalid one cycle after grant, stall_i=0 -> imem_addr_o 0,4,8; instr_valid_o pulses with instr_pc_o 0,4,8 every 3 cycles.
REQ-035 The bench SHALL apply: redirect to 0x100 in WAIT, rvalid on the next cycle -> that data is never presented; flush_o is a single pulse; the next imem_addr_o is 0x100.
REQ-036 The bench SHALL apply: stall_i=1 for 5 cycles in OUT with instr 0x00A00093 at pc 0x8 -> outputs stable for all 5 cycles and imem_req_o=0; fetch of 0xC follows release.
REQ-037 The bench SHALL apply: redirect to 0x102 -> one misalign_o pulse, no flush_o, and sequential fetch continues.
REQ-038 The bench SHALL apply: redirect to 0xFFFFFFFC, then consume -> next imem_addr_o is 0x00000000.
REQ-039 The bench SHALL apply: rst_n low in WAIT, with rvalid arriving during IDLE after release -> outputs 0 immediately, the late rvalid is ignored, and the first fetch is at RESET_PC.
